alien_bomb: RTL and testbench

ALIEN_BOMB -- requirements
Module: alien_bomb

---
 rtl/alien_bomb_pkg.sv | 14 +
 rtl/alien_bomb_if.sv | 23 ++
 rtl/timer_1us.sv | 16 +
 rtl/alien_bomb.sv | 85 ++++++++
 tb/tb_alien_bomb.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/alien_bomb_pkg.sv
// alien_bomb_pkg: shared game grid constants, launcher states and the column-select LFSR step
package alien_bomb_pkg;
  localparam int COL_W = 5;
  localparam int ROW_W = 4;
  localparam int NUM_COLS = 32;
  localparam int NUM_SLOTS = 2;
  localparam logic [ROW_W-1:0] SHIP_ROW_DEF = 4'd13;
  localparam logic [ROW_W-1:0] BOTTOM_ROW_DEF = 4'd14;
  localparam logic [ROW_W-1:0] OFF_ROW = 4'd15;
  typedef enum logic {COOLDOWN, SELECT} launch_state_t;
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction
endpackage

// File: rtl/alien_bomb_if.sv
// alien_bomb_if: game-state inputs and bomb-slot outputs of the alien bomb launcher
interface alien_bomb_if;
  import alien_bomb_pkg::*;
  logic enable;
  logic [NUM_COLS-1:0] column_alive;
  logic [ROW_W-1:0] formation_bottom_y;
  logic [COL_W-1:0] ship_x;
  logic bullet_flying;
  logic [COL_W-1:0] bullet_x;
  logic [ROW_W-1:0] bullet_y;
  logic bomb0_active, bomb1_active;
  logic [COL_W-1:0] bomb0_x, bomb1_x;
  logic [ROW_W-1:0] bomb0_y, bomb1_y;
  logic ship_hit, bullet_cancel;
  modport master (
    output enable, column_alive, formation_bottom_y, ship_x, bullet_flying, bullet_x, bullet_y,
    input bomb0_active, bomb0_x, bomb0_y, bomb1_active, bomb1_x, bomb1_y, ship_hit, bullet_cancel
  );
  modport slave (
    input enable, column_alive, formation_bottom_y, ship_x, bullet_flying, bullet_x, bullet_y,
    output bomb0_active, bomb0_x, bomb0_y, bomb1_active, bomb1_x, bomb1_y, ship_hit, bullet_cancel
  );
endinterface

// File: rtl/timer_1us.sv
// timer_1us: one-cycle tick every CYCLES enabled clock cycles
module timer_1us #(
  parameter int CYCLES = 36
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_tick
);
  localparam int W = CYCLES > 1 ? $clog2(CYCLES) : 1;
  logic [W-1:0] r_cnt;
  assign o_tick = i_en && r_cnt == W'(CYCLES - 1);
  always_ff @(posedge clk)
    if (rst) r_cnt <= '0;
    else if (i_en) r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/alien_bomb.sv
// alien_bomb: launches alien bombs into two slots, moves them per tick and resolves ship/bullet/bottom hits
module alien_bomb
  import alien_bomb_pkg::*;
#(
  parameter int TICK_CYCLES = 120000,
  parameter int COOLDOWN_TICKS = 8,
  parameter logic [ROW_W-1:0] SHIP_ROW = SHIP_ROW_DEF,
  parameter logic [ROW_W-1:0] BOTTOM_ROW = BOTTOM_ROW_DEF,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic clk_36MHz,
  input logic reset,
  alien_bomb_if.slave bus
);
  localparam int CD_W = COOLDOWN_TICKS > 0 ? $clog2(COOLDOWN_TICKS + 1) : 1;
  logic w_tick;
  logic [15:0] r_lfsr;
  logic [COL_W-1:0] w_cand;
  launch_state_t r_state, w_state_nx;
  logic [CD_W-1:0] r_cd, w_cd_nx;
  logic w_launch, w_slot_sel;
  logic [NUM_SLOTS-1:0] w_act, w_hit_ship, w_hit_bul, w_clear;
  logic [NUM_SLOTS*COL_W-1:0] w_x;
  logic [NUM_SLOTS*ROW_W-1:0] w_y;

  timer_1us #(.CYCLES(TICK_CYCLES)) u_tick (
    .clk(clk_36MHz), .rst(reset), .i_en(bus.enable), .o_tick(w_tick)
  );

  // LFSR free-runs regardless of enable so column choice stays unpredictable
  always_ff @(posedge clk_36MHz) r_lfsr <= reset ? LFSR_SEED : lfsr_next(r_lfsr);
  assign w_cand = r_lfsr[COL_W-1:0];
  assign w_slot_sel = w_act[0];
  assign w_launch = r_state == SELECT && bus.enable && bus.column_alive[w_cand] && !(&w_act)
                    && bus.formation_bottom_y < BOTTOM_ROW;

  always_ff @(posedge clk_36MHz) begin
    r_state <= reset ? COOLDOWN : w_state_nx;
    r_cd <= reset ? CD_W'(COOLDOWN_TICKS) : w_cd_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_cd_nx = r_cd;
    if (r_state == COOLDOWN) begin
      if (r_cd == '0) w_state_nx = SELECT;
      else if (w_tick) w_cd_nx = r_cd - 1'b1;
    end else if (w_launch) begin
      w_state_nx = COOLDOWN;
      w_cd_nx = CD_W'(COOLDOWN_TICKS);
    end
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    logic r_act;
    logic [COL_W-1:0] r_x;
    logic [ROW_W-1:0] r_y;
    assign w_hit_ship[i] = r_act && r_y == SHIP_ROW && r_x == bus.ship_x;
    assign w_hit_bul[i] = r_act && !w_hit_ship[i] && bus.bullet_flying && r_x == bus.bullet_x
                          && (r_y == bus.bullet_y || {1'b0, r_y} + 1'b1 == {1'b0, bus.bullet_y});
    assign w_clear[i] = w_hit_ship[i] || w_hit_bul[i] || (r_act && r_y == BOTTOM_ROW);
    assign w_act[i] = r_act;
    assign w_x[i*COL_W +: COL_W] = r_x;
    assign w_y[i*ROW_W +: ROW_W] = r_y;
    always_ff @(posedge clk_36MHz)
      if (reset || w_clear[i]) begin
        r_act <= 1'b0;
        r_x <= '0;
        r_y <= OFF_ROW;
      end else if (w_launch && w_slot_sel == 1'(i)) begin
        r_act <= 1'b1;
        r_x <= w_cand;
        r_y <= bus.formation_bottom_y + 1'b1;
      end else if (r_act && w_tick) r_y <= r_y + 1'b1;
  end

  assign bus.bomb0_active = w_act[0];
  assign bus.bomb1_active = w_act[1];
  assign bus.bomb0_x = w_x[0 +: COL_W];
  assign bus.bomb1_x = w_x[COL_W +: COL_W];
  assign bus.bomb0_y = w_y[0 +: ROW_W];
  assign bus.bomb1_y = w_y[ROW_W +: ROW_W];
  assign bus.ship_hit = !reset && |w_hit_ship;
  assign bus.bullet_cancel = !reset && |w_hit_bul;
endmodule

// File: tb/tb_alien_bomb.sv
// tb_alien_bomb: directed vector table plus multi-cycle sequences for the alien bomb launcher
module tb_alien_bomb;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alien_bomb_if bus();
  alien_bomb #(.TICK_CYCLES(4), .COOLDOWN_TICKS(2)) dut (
    .clk_36MHz(clk), .reset(reset), .bus(bus)
  );

  int n_chk = 0, n_pass = 0;
  int n_ship = 0, n_cancel = 0, n_busy = 0;
  logic [15:0] m_lfsr, m_prev;

  always @(posedge clk) begin
    m_prev <= m_lfsr;
    m_lfsr <= reset ? 16'hACE1 : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  always @(negedge clk) begin
    #3;
    if (bus.ship_hit) n_ship++;
    if (bus.bullet_cancel) n_cancel++;
    if (bus.bomb0_active || bus.bomb1_active) n_busy++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.column_alive = '0;
    bus.formation_bottom_y = 4'd0;
    bus.ship_x = 5'd31;
    bus.bullet_flying = 1'b0;
    bus.bullet_x = 5'd0;
    bus.bullet_y = 4'd0;
    repeat (2) cyc();
    reset = 1'b0;
  endtask

  typedef struct {
    int col;
    logic [3:0] fby;
    logic [4:0] sx;
    logic bf;
    logic [4:0] bx;
    logic [3:0] by;
    logic e_hit;
    logic e_can;
    logic e_clr;
  } vec_t;
  vec_t tv[9];

  initial begin
    int s_ship, s_can, s_busy, cnt, x0, x1, x1_moves;
    logic [3:0] y_old;
    tv[0] = '{7,  4'd12, 5'd7,  1'b0, 5'd0,  4'd0,  1'b1, 1'b0, 1'b1};
    tv[1] = '{7,  4'd12, 5'd6,  1'b0, 5'd0,  4'd0,  1'b0, 1'b0, 1'b0};
    tv[2] = '{3,  4'd8,  5'd0,  1'b1, 5'd3,  4'd10, 1'b0, 1'b1, 1'b1};
    tv[3] = '{3,  4'd8,  5'd0,  1'b1, 5'd3,  4'd9,  1'b0, 1'b1, 1'b1};
    tv[4] = '{3,  4'd8,  5'd0,  1'b1, 5'd3,  4'd11, 1'b0, 1'b0, 1'b0};
    tv[5] = '{3,  4'd8,  5'd0,  1'b0, 5'd3,  4'd10, 1'b0, 1'b0, 1'b0};
    tv[6] = '{5,  4'd12, 5'd5,  1'b1, 5'd5,  4'd13, 1'b1, 1'b0, 1'b1};
    tv[7] = '{9,  4'd13, 5'd0,  1'b0, 5'd0,  4'd0,  1'b0, 1'b0, 1'b1};
    tv[8] = '{20, 4'd4,  5'd20, 1'b1, 5'd21, 4'd5,  1'b0, 1'b0, 1'b0};

    do_reset();
    chk("rst_b0_active", bus.bomb0_active, 0);
    chk("rst_b0_x", bus.bomb0_x, 0);
    chk("rst_b0_y", bus.bomb0_y, 15);
    chk("rst_b1_active", bus.bomb1_active, 0);
    chk("rst_b1_x", bus.bomb1_x, 0);
    chk("rst_b1_y", bus.bomb1_y, 15);
    chk("rst_ship_hit", bus.ship_hit, 0);
    chk("rst_bullet_cancel", bus.bullet_cancel, 0);

    // no live column: nothing ever launches
    bus.enable = 1'b1;
    s_busy = n_busy;
    repeat (100) cyc();
    chk("idle_no_bomb", n_busy - s_busy, 0);

    // launch from all-alive formation, then fall to the bottom
    s_ship = n_ship;
    s_can = n_cancel;
    bus.column_alive = 32'h7FFF_FFFF;
    bus.formation_bottom_y = 4'd5;
    for (int k = 0; k < 100 && !bus.bomb0_active; k++) cyc();
    chk("fall_launch", bus.bomb0_active, 1);
    chk("fall_x_lfsr", bus.bomb0_x, m_prev[4:0]);
    chk("fall_y0", bus.bomb0_y, 6);
    bus.column_alive = '0;
    for (int k = 1; k <= 8; k++) begin
      y_old = bus.bomb0_y;
      cnt = 0;
      while (bus.bomb0_y == y_old && cnt < 20) begin
        cyc();
        cnt++;
      end
      chk($sformatf("fall_y%0d", k), bus.bomb0_y, 6 + k);
      if (k > 1) chk($sformatf("fall_period%0d", k), cnt, 4);
    end
    cyc();
    chk("bottom_active", bus.bomb0_active, 0);
    chk("bottom_x", bus.bomb0_x, 0);
    chk("bottom_y", bus.bomb0_y, 15);
    chk("bottom_no_hit", n_ship - s_ship, 0);
    chk("bottom_no_cancel", n_cancel - s_can, 0);

    // collision vectors, movement frozen by enable=0
    for (int i = 0; i < 9; i++) begin
      do_reset();
      bus.enable = 1'b1;
      bus.column_alive = 32'd1 << tv[i].col;
      bus.formation_bottom_y = tv[i].fby;
      bus.ship_x = 5'(tv[i].col) ^ 5'd1;
      for (int k = 0; k < 2000 && !bus.bomb0_active; k++) cyc();
      chk($sformatf("v%0d_launch", i), bus.bomb0_active, 1);
      chk($sformatf("v%0d_x", i), bus.bomb0_x, tv[i].col);
      chk($sformatf("v%0d_y", i), bus.bomb0_y, tv[i].fby + 1);
      bus.enable = 1'b0;
      bus.column_alive = '0;
      bus.ship_x = tv[i].sx;
      bus.bullet_flying = tv[i].bf;
      bus.bullet_x = tv[i].bx;
      bus.bullet_y = tv[i].by;
      #1;
      chk($sformatf("v%0d_ship_hit", i), bus.ship_hit, tv[i].e_hit);
      chk($sformatf("v%0d_cancel", i), bus.bullet_cancel, tv[i].e_can);
      cyc();
      chk($sformatf("v%0d_active_after", i), bus.bomb0_active, !tv[i].e_clr);
      chk($sformatf("v%0d_pulse_drop", i), bus.ship_hit | bus.bullet_cancel, 0);
      if (!tv[i].e_clr) chk($sformatf("v%0d_frozen_y", i), bus.bomb0_y, tv[i].fby + 1);
    end

    // formation at the bottom row suppresses launches
    do_reset();
    bus.enable = 1'b1;
    bus.column_alive = 32'h7FFF_FFFF;
    bus.formation_bottom_y = 4'd14;
    s_busy = n_busy;
    repeat (100) cyc();
    chk("low_formation_no_bomb", n_busy - s_busy, 0);

    // both slots busy: stall, then refill slot 0 first
    do_reset();
    bus.enable = 1'b1;
    bus.column_alive = 32'h7FFF_FFFF;
    bus.formation_bottom_y = 4'd4;
    for (int k = 0; k < 300 && !(bus.bomb0_active && bus.bomb1_active); k++) cyc();
    chk("two_busy", bus.bomb0_active && bus.bomb1_active, 1);
    x0 = bus.bomb0_x;
    x1 = bus.bomb1_x;
    x1_moves = 0;
    for (int k = 0; k < 200 && bus.bomb0_active; k++) begin
      cyc();
      if (bus.bomb0_active && bus.bomb0_x != x0) x1_moves++;
      if (bus.bomb1_x != x1) x1_moves++;
    end
    chk("stall_slot0_cleared", bus.bomb0_active, 0);
    chk("stall_slot0_y", bus.bomb0_y, 15);
    chk("stall_slot1_alive", bus.bomb1_active, 1);
    chk("stall_x_stable", x1_moves, 0);
    for (int k = 0; k < 200 && !bus.bomb0_active; k++) cyc();
    chk("refill_slot0", bus.bomb0_active, 1);
    chk("refill_y", bus.bomb0_y, 5);
    chk("refill_slot1_kept", bus.bomb1_active, 1);

    // reset mid-flight with a pending bullet collision
    s_ship = n_ship;
    s_can = n_cancel;
    reset = 1'b1;
    bus.bullet_flying = 1'b1;
    bus.bullet_x = bus.bomb0_x;
    bus.bullet_y = bus.bomb0_y;
    #1;
    chk("rst_cycle_cancel", bus.bullet_cancel, 0);
    chk("rst_cycle_hit", bus.ship_hit, 0);
    cyc();
    chk("midrst_b0_active", bus.bomb0_active, 0);
    chk("midrst_b1_active", bus.bomb1_active, 0);
    chk("midrst_b0_y", bus.bomb0_y, 15);
    chk("midrst_b1_y", bus.bomb1_y, 15);
    chk("midrst_b1_x", bus.bomb1_x, 0);
    reset = 1'b0;
    cyc();
    chk("midrst_no_pulses", (n_ship - s_ship) + (n_cancel - s_can), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
